ram_seq: RTL

- Memory access sequencer sitting directly upstream of the 256x8 synchronous RAM in the accumulator processor.
- Accepts single load/store/wipe requests from the control unit over a busy/valid handshake.
- Drives the RAM's enab/rw/Addr/data_in/clr pins with correct timing.
- Returns read data with a one-cycle valid strobe, hiding the RAM's registered-read latency and its 0x55 disabled-output value.

---
 rtl/ram_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ram_seq.sv
// Sequencer between the control unit and the 256x8 synchronous RAM.
// Optional write-back verify read is enabled with `define RAM_SEQ_WRITE_VERIFY_EN.
module ram_seq #(
    parameter int d_width = 8,
    parameter int a_width = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req,
    input  logic               we,
    input  logic [a_width-1:0] addr,
    input  logic [d_width-1:0] wdata,
    input  logic               wipe,
    output logic               busy,
    output logic               rd_valid,
    output logic [d_width-1:0] rd_data,
    output logic               verify_err,
    output logic               ram_enab,
    output logic               ram_rw,
    output logic [a_width-1:0] ram_addr,
    output logic [d_width-1:0] ram_wdata,
    output logic               ram_clr,
    input  logic [d_width-1:0] ram_rdata
);

`ifdef RAM_SEQ_WRITE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, WIPE, VFY, VFY_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, WIPE} state_t;
`endif

    state_t             state_reg;
    logic               busy_reg;
    logic               rd_valid_reg;
    logic [d_width-1:0] rd_data_reg;
    logic               ram_enab_reg;
    logic               ram_rw_reg;
    logic [a_width-1:0] ram_addr_reg;
    logic [d_width-1:0] ram_wdata_reg;
    logic               ram_clr_reg;
`ifdef RAM_SEQ_WRITE_VERIFY_EN
    logic               verify_err_reg;
`endif

    // ram_rdata is only sampled in the *_WAIT states, so the RAM's idle
    // 0x55 output can never leak into rd_data.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_data_reg   <= '0;
            ram_enab_reg  <= 1'b0;
            ram_rw_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            ram_clr_reg   <= 1'b1;
`ifdef RAM_SEQ_WRITE_VERIFY_EN
            verify_err_reg <= 1'b0;
`endif
        end else begin
            rd_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wipe) begin
                        ram_clr_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= WIPE;
`ifdef RAM_SEQ_WRITE_VERIFY_EN
                        verify_err_reg <= 1'b0;
`endif
                    end else if (req) begin
                        ram_addr_reg  <= addr;
                        ram_wdata_reg <= wdata;
                        ram_enab_reg  <= 1'b1;
                        ram_rw_reg    <= we;
                        busy_reg      <= 1'b1;
                        state_reg     <= we ? WR : RD;
                    end
                end
                WIPE: begin
                    ram_clr_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                WR: begin
`ifdef RAM_SEQ_WRITE_VERIFY_EN
                    // Read the word straight back to confirm the write landed.
                    ram_enab_reg <= 1'b1;
                    ram_rw_reg   <= 1'b0;
                    state_reg    <= VFY;
`else
                    ram_enab_reg <= 1'b0;
                    ram_rw_reg   <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
`endif
                end
                RD: begin
                    ram_enab_reg <= 1'b0;
                    state_reg    <= RD_WAIT;
                end
                RD_WAIT: begin
                    rd_data_reg  <= ram_rdata;
                    rd_valid_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
`ifdef RAM_SEQ_WRITE_VERIFY_EN
                VFY: begin
                    ram_enab_reg <= 1'b0;
                    state_reg    <= VFY_WAIT;
                end
                VFY_WAIT: begin
                    if (ram_rdata != ram_wdata_reg)
                        verify_err_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
`endif
                default: begin
                    ram_enab_reg <= 1'b0;
                    ram_rw_reg   <= 1'b0;
                    ram_clr_reg  <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign ram_enab  = ram_enab_reg;
    assign ram_rw    = ram_rw_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign ram_clr   = ram_clr_reg;
`ifdef RAM_SEQ_WRITE_VERIFY_EN
    assign verify_err = verify_err_reg;
`else
    assign verify_err = 1'b0;
`endif

endmodule
